uart_fifo_ctrl: RTL

Parametrised successor to the SoC system UART, sitting on the same 4-bit-address, 32-bit memory-mapped slave bus. Adds TX/RX FIFOs, 16x-oversampled receive, and runtime-selectable frame format: 5-8 data bits, none/even/odd parity, 1/2 stop bits. Adds sticky error flags, internal loopback and a level interrupt.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART: register map, field positions, frame state.
package uart_pkg;

   localparam logic [3:0] ADDR_STATUS = 4'h0;
   localparam logic [3:0] ADDR_CTRL   = 4'h4;
   localparam logic [3:0] ADDR_DATA   = 4'h8;
   localparam logic [3:0] ADDR_DIV    = 4'hC;

   localparam int unsigned CTRL_W      = 11;
   localparam int unsigned CTRL_TX_EN  = 5;
   localparam int unsigned CTRL_RX_EN  = 6;
   localparam int unsigned CTRL_LOOP   = 7;
   localparam int unsigned CTRL_IE_RX  = 8;
   localparam int unsigned CTRL_IE_TX  = 9;
   localparam int unsigned CTRL_IE_ERR = 10;
   localparam logic [CTRL_W-1:0] CTRL_RESET = 11'h060;

   localparam int unsigned ST_PARITY_ERR = 4;
   localparam int unsigned ST_FRAME_ERR  = 5;
   localparam int unsigned ST_RX_OVERRUN = 6;
   localparam int unsigned ST_TX_OVERFLW = 7;

   // parity field: bit 1 enables, bit 0 selects odd
   localparam logic [1:0] PAR_EVEN = 2'b10;
   localparam logic [1:0] PAR_ODD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uartState_t;

   // Mirrors CTRL[4:0]
   typedef struct packed {
      logic       stop2;
      logic [1:0] parity;
      logic [1:0] dataSel;
   } frameFmt_t;

   // Index of the last data bit: 8,7,6,5 bits -> 7,6,5,4
   function automatic logic [2:0] lastBitIdx(input logic [1:0] dataSel);
      return 3'd7 - 3'(dataSel);
   endfunction

   // Mask of the valid character bits
   function automatic logic [7:0] charMask(input logic [1:0] dataSel);
      return 8'hFF >> dataSel;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pushData,
   input  logic                       pop,
   output logic [WIDTH-1:0]           popData,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign doPop   = pop & ~empty;
   assign doPush  = push & (~full | doPop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign popData = mem[rdPtr];

   // Storage array, written on accepted pushes
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART with TX/RX FIFOs, 16x oversampled receive and runtime frame format.
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd26,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        read,
   output logic [31:0] readData,
   input  logic        write,
   input  logic [31:0] writeData,
   output logic        waitrequest,
   output logic        irq,
   input  logic        RX,
   output logic        TX
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [CTRL_W-1:0]      ctrl;
   frameFmt_t              ctrlFmt;
   logic [15:0]            divReg;
   logic [15:0]            divCnt;
   logic                   tick16;
   logic                   parityErr, frameErr, rxOverrun, txOverflow;
   logic                   wrStatus, wrCtrl, wrData, wrDiv, rdData;

   logic [7:0]             txHead, rxHead;
   logic                   txFull, txFifoEmpty, rxFull, rxFifoEmpty;
   logic [LVL_W-1:0]       txLevel, rxLevel;
   logic                   txPop, rxPush, rxPop;

   uartState_t             txState;
   logic [4:0]             txTickCnt;
   logic [4:0]             txLastTick;
   logic [2:0]             txBitIdx;
   logic [7:0]             txShift;
   logic                   txParBit, txLine, txStop2, txParEn;
   logic [1:0]             txDataSel;
   logic                   txStart;

   uartState_t             rxState;
   logic [SYNC_STAGES-1:0] rxSync;
   logic                   rxIn, rxArmed, rxSampleNow;
   logic [3:0]             rxTickCnt;
   logic [2:0]             rxBitIdx;
   logic [7:0]             rxShift;
   logic                   rxParAcc, rxParErrPend, rxParEn, rxParOdd;
   logic [1:0]             rxDataSel;
   logic                   txEmptyStat;
   logic [31:0]            statusWord;
   logic                   unusedBits;

   assign waitrequest = 1'b0;
   assign unusedBits  = ^writeData[31:16];
   assign ctrlFmt     = frameFmt_t'(ctrl[4:0]);

   assign wrStatus = write && (address == ADDR_STATUS);
   assign wrCtrl   = write && (address == ADDR_CTRL);
   assign wrData   = write && (address == ADDR_DATA);
   assign wrDiv    = write && (address == ADDR_DIV);
   assign rdData   = read  && (address == ADDR_DATA);
   assign rxPop    = rdData && !rxFifoEmpty;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
      .clk(clk), .reset(reset), .push(wrData), .pushData(writeData[7:0]), .pop(txPop),
      .popData(txHead), .full(txFull), .empty(txFifoEmpty), .level(txLevel)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rxFifo (
      .clk(clk), .reset(reset), .push(rxPush), .pushData(rxShift), .pop(rxPop),
      .popData(rxHead), .full(rxFull), .empty(rxFifoEmpty), .level(rxLevel)
   );

   // Baud generator: one tick16 pulse per DIV+1 clocks, restarted by a DIV write
   assign tick16 = (divCnt == divReg);
   always_ff @(posedge clk) begin
      if (reset)                 divCnt <= '0;
      else if (wrDiv || tick16)  divCnt <= '0;
      else                       divCnt <= divCnt + 16'd1;
   end

   // Control registers and sticky error flags (a set beats a same-cycle clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl       <= CTRL_RESET;
         divReg     <= DEFAULT_DIV;
         parityErr  <= 1'b0;
         frameErr   <= 1'b0;
         rxOverrun  <= 1'b0;
         txOverflow <= 1'b0;
      end else begin
         if (wrCtrl) ctrl   <= writeData[CTRL_W-1:0];
         if (wrDiv)  divReg <= writeData[15:0];
         parityErr  <= (rxPush && rxParErrPend) ||
                       (parityErr && !(wrStatus && writeData[ST_PARITY_ERR]));
         frameErr   <= (rxPush && !rxIn) ||
                       (frameErr && !(wrStatus && writeData[ST_FRAME_ERR]));
         rxOverrun  <= (rxPush && rxFull && !rxPop) ||
                       (rxOverrun && !(wrStatus && writeData[ST_RX_OVERRUN]));
         txOverflow <= (wrData && txFull && !txPop) ||
                       (txOverflow && !(wrStatus && writeData[ST_TX_OVERFLW]));
      end
   end

   // A frame starts from IDLE or straight out of the last stop tick, so back-to-back frames have no gap
   assign txLastTick = (txState == S_STOP && txStop2) ? 5'd31 : 5'd15;
   assign txStart    = tick16 && ctrl[CTRL_TX_EN] && !txFifoEmpty &&
                       (txState == S_IDLE || (txState == S_STOP && txTickCnt == txLastTick));
   assign txPop      = txStart;

   // TX frame sequencer; format is latched when the frame starts
   always_ff @(posedge clk) begin
      if (reset) begin
         txState   <= S_IDLE;
         txLine    <= 1'b1;
         txTickCnt <= '0;
         txBitIdx  <= '0;
         txShift   <= '0;
         txParBit  <= 1'b0;
         txStop2   <= 1'b0;
         txParEn   <= 1'b0;
         txDataSel <= '0;
      end else if (txStart) begin
         txState   <= S_START;
         txLine    <= 1'b0;
         txTickCnt <= '0;
         txBitIdx  <= '0;
         txShift   <= txHead;
         txParBit  <= (^(txHead & charMask(ctrlFmt.dataSel))) ^ ctrlFmt.parity[0];
         txStop2   <= ctrlFmt.stop2;
         txParEn   <= ctrlFmt.parity[1];
         txDataSel <= ctrlFmt.dataSel;
      end else if (tick16 && txState != S_IDLE) begin
         if (txTickCnt != txLastTick) begin
            txTickCnt <= txTickCnt + 5'd1;
         end else begin
            txTickCnt <= '0;
            case (txState)
               S_START: begin
                  txState <= S_DATA;
                  txLine  <= txShift[0];
               end
               S_DATA: begin
                  txShift <= txShift >> 1;
                  if (txBitIdx == lastBitIdx(txDataSel)) begin
                     txState <= txParEn ? S_PARITY : S_STOP;
                     txLine  <= txParEn ? txParBit : 1'b1;
                  end else begin
                     txBitIdx <= txBitIdx + 3'd1;
                     txLine   <= txShift[1];
                  end
               end
               S_PARITY: begin
                  txState <= S_STOP;
                  txLine  <= 1'b1;
               end
               default: begin
                  txState <= S_IDLE;
                  txLine  <= 1'b1;
               end
            endcase
         end
      end
   end

   // Serial output pin, held high in loopback
   always_ff @(posedge clk) begin
      if (reset) TX <= 1'b1;
      else       TX <= ctrl[CTRL_LOOP] | txLine;
   end

   // RX input synchroniser
   always_ff @(posedge clk) begin
      if (reset) rxSync <= '1;
      else       rxSync <= {rxSync[SYNC_STAGES-2:0], RX};
   end

   assign rxIn        = ctrl[CTRL_LOOP] ? txLine : rxSync[SYNC_STAGES-1];
   assign rxSampleNow = tick16 && (rxTickCnt == ((rxState == S_START) ? 4'd7 : 4'd15));
   assign rxPush      = (rxState == S_STOP) && rxSampleNow;

   // RX frame sequencer: mid-bit sampling, start re-armed only after a high level
   always_ff @(posedge clk) begin
      if (reset) begin
         rxState      <= S_IDLE;
         rxArmed      <= 1'b0;
         rxTickCnt    <= '0;
         rxBitIdx     <= '0;
         rxShift      <= '0;
         rxParAcc     <= 1'b0;
         rxParErrPend <= 1'b0;
         rxParEn      <= 1'b0;
         rxParOdd     <= 1'b0;
         rxDataSel    <= '0;
      end else if (rxState == S_IDLE) begin
         rxTickCnt <= '0;
         if (rxIn) begin
            rxArmed <= 1'b1;
         end else if (rxArmed && ctrl[CTRL_RX_EN]) begin
            rxState      <= S_START;
            rxArmed      <= 1'b0;
            rxBitIdx     <= '0;
            rxShift      <= '0;
            rxParAcc     <= 1'b0;
            rxParErrPend <= 1'b0;
            rxParEn      <= ctrlFmt.parity[1];
            rxParOdd     <= ctrlFmt.parity[0];
            rxDataSel    <= ctrlFmt.dataSel;
         end
      end else if (tick16) begin
         if (!rxSampleNow) begin
            rxTickCnt <= rxTickCnt + 4'd1;
         end else begin
            rxTickCnt <= '0;
            case (rxState)
               S_START: rxState <= rxIn ? S_IDLE : S_DATA;
               S_DATA: begin
                  rxShift[rxBitIdx] <= rxIn;
                  rxParAcc          <= rxParAcc ^ rxIn;
                  if (rxBitIdx == lastBitIdx(rxDataSel)) rxState  <= rxParEn ? S_PARITY : S_STOP;
                  else                                   rxBitIdx <= rxBitIdx + 3'd1;
               end
               S_PARITY: begin
                  rxParErrPend <= (rxParAcc ^ rxIn) != rxParOdd;
                  rxState      <= S_STOP;
               end
               default: rxState <= S_IDLE;
            endcase
         end
      end
   end

   assign txEmptyStat = txFifoEmpty && (txState == S_IDLE);
   assign statusWord  = {8'(txLevel), 8'(rxLevel), 8'h00,
                         txOverflow, rxOverrun, frameErr, parityErr,
                         (rxState != S_IDLE), txEmptyStat, !rxFifoEmpty, !txFull};

   // Bus read mux, zero when no read strobe
   always_comb begin
      readData = '0;
      if (read) begin
         case (address)
            ADDR_STATUS: readData = statusWord;
            ADDR_CTRL:   readData = {21'd0, ctrl};
            ADDR_DATA:   readData = {23'd0, !rxFifoEmpty, rxFifoEmpty ? 8'h00 : rxHead};
            ADDR_DIV:    readData = {16'd0, divReg};
            default:     readData = '0;
         endcase
      end
   end

   // Level interrupt, one clock behind its sources
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= (ctrl[CTRL_IE_RX] && !rxFifoEmpty) ||
                        (ctrl[CTRL_IE_TX] && txEmptyStat) ||
                        (ctrl[CTRL_IE_ERR] && (parityErr || frameErr || rxOverrun || txOverflow));
   end

endmodule
